// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: accepts an operand pair and opcode, processes one bit per clock LSB first.
// Optional overflow output (out_ovf) is built when BSALU_OVERFLOW_EN is defined.
module bit_serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero
`ifdef BSALU_OVERFLOW_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_INC   = 3'b101,
        OP_DEC   = 3'b110,
        OP_PASSB = 3'b111
    } op_e;

    state_e           r_state;
    state_e           w_next_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic w_a;
    logic w_b;
    logic w_sum;
    logic w_carry_next;
    logic w_c0;
    logic w_last;
    logic w_accept;

    assign w_a      = r_a[0];
    assign w_b      = r_b[0];
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_c0     = (in_op == OP_SUB) || (in_op == OP_INC);

    // Per-bit sum and the selected next-carry candidate for the current opcode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_sum        = 1'b0;
        w_carry_next = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_sum        = w_a ^ w_b ^ r_carry;
                w_carry_next = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);
            end
            OP_SUB: begin
                w_sum        = w_a ^ ~w_b ^ r_carry;
                w_carry_next = (w_a & ~w_b) | (w_a & r_carry) | (~w_b & r_carry);
            end
            OP_AND:   w_sum = w_a & w_b;
            OP_OR:    w_sum = w_a | w_b;
            OP_XOR:   w_sum = w_a ^ w_b;
            OP_INC: begin
                w_sum        = w_a ^ r_carry;
                w_carry_next = w_a & r_carry;
            end
            OP_DEC: begin
                w_sum        = ~(w_a ^ r_carry);
                w_carry_next = w_a | r_carry;
            end
            OP_PASSB: w_sum = w_b;
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_SHIFT;
            S_SHIFT: if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_op    <= op_e'(in_op);
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= w_c0;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_carry  <= w_carry_next;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_result;
    assign out_carry  = r_carry;
    // Gated by DONE so the idle/reset value of out_zero is 0 even with a cleared result.
    assign out_zero   = (r_state == S_DONE) && ~|r_result;

`ifdef BSALU_OVERFLOW_EN
    logic r_cin_msb;
    logic w_arith;

    // While the last bit is being processed, r_carry is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cin_msb <= 1'b0;
        end else if ((r_state == S_SHIFT) && w_last) begin
            r_cin_msb <= r_carry;
        end
    end

    assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_INC) || (r_op == OP_DEC);
    assign out_ovf = (r_state == S_DONE) && w_arith && (r_cin_msb ^ r_carry);
`endif

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq (WIDTH=8): vector table, scoreboard queue and
// hand-written backpressure / mid-shift reset sequences.
module tb_bit_serial_alu_seq;

    localparam int WIDTH = 8;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_result;
        logic             exp_carry;
        logic             exp_zero;
        logic             exp_ovf;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
`ifdef BSALU_OVERFLOW_EN
    logic             out_ovf;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t exp_q[$];

    bit_serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_carry (out_carry),
        .out_zero  (out_zero)
`ifdef BSALU_OVERFLOW_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent arithmetic reference for randomised transactions.
    function automatic vec_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        vec_t     v;
        logic [WIDTH:0] t;
        v.op = op; v.a = a; v.b = b;
        v.exp_carry = 1'b0;
        v.exp_ovf   = 1'b0;
        case (op)
            3'd0: begin
                t = {1'b0, a} + {1'b0, b};
                v.exp_result = t[WIDTH-1:0]; v.exp_carry = t[WIDTH];
                v.exp_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                t = {1'b0, a} + {1'b0, ~b} + 1;
                v.exp_result = t[WIDTH-1:0]; v.exp_carry = t[WIDTH];
                v.exp_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2: v.exp_result = a & b;
            3'd3: v.exp_result = a | b;
            3'd4: v.exp_result = a ^ b;
            3'd5: begin
                t = {1'b0, a} + 1;
                v.exp_result = t[WIDTH-1:0]; v.exp_carry = t[WIDTH];
                v.exp_ovf = (a == {1'b0, {(WIDTH-1){1'b1}}});
            end
            3'd6: begin
                v.exp_result = a - 1'b1; v.exp_carry = (a != 0);
                v.exp_ovf = (a == {1'b1, {(WIDTH-1){1'b0}}});
            end
            default: v.exp_result = b;
        endcase
        v.exp_zero = (v.exp_result == 0);
        return v;
    endfunction

    task automatic send(input vec_t v);
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_op = v.op; in_valid = 1'b1;
        check("in_ready before accept", in_ready, 1);
        exp_q.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs after acceptance; they must have no effect.
        in_a  = WIDTH'($urandom);
        in_b  = WIDTH'($urandom);
        in_op = 3'($urandom);
    endtask

    // Waits for out_valid (bounded), compares against the scoreboard, optionally holds
    // off the consumer while checking stability, then consumes the result.
    task automatic receive(input int hold, input bit poke_valid);
        int   lat;
        vec_t e;
        logic [WIDTH-1:0] r0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, WIDTH);
        if (exp_q.size() == 0) begin
            check("scoreboard nonempty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check("out_result", out_result, e.exp_result);
        check("out_carry", out_carry, e.exp_carry);
        check("out_zero", out_zero, e.exp_zero);
`ifdef BSALU_OVERFLOW_EN
        check("out_ovf", out_ovf, e.exp_ovf);
`endif
        r0 = out_result;
        for (int i = 0; i < hold; i++) begin
            if (poke_valid) begin
                in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_op = 3'd0;
            end
            @(posedge clk); #1;
            check("hold out_valid", out_valid, 1);
            check("hold in_ready", in_ready, 0);
            check("hold out_result", out_result, r0);
            check("hold out_carry", out_carry, e.exp_carry);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid after consume", out_valid, 0);
        check("in_ready after consume", in_ready, 1);
    endtask

    task automatic run_vec(input vec_t v);
        send(v);
        receive(0, 1'b0);
    endtask

    vec_t vecs[13];

    initial begin
        // {op, a, b, result, carry, zero, ovf}
        vecs[0]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{3'd1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd4, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd5, 8'hFF, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{3'd6, 8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd7, 8'hC3, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{3'd2, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'd6, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_result", out_result, 0);
        check("reset out_carry", out_carry, 0);
        check("reset out_zero", out_zero, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Backpressure: consumer stalls 5 cycles with a competing request on in_valid.
        send(vecs[3]);
        receive(5, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) check("no duplicate delivery", out_valid, 0);
        end
        check("idle after stall", in_ready, 1);

        // Reset while processing bit 4 aborts the transaction.
        send(model(3'd0, 8'h55, 8'h11));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0; #1;
        check("midreset in_ready", in_ready, 1);
        check("midreset out_valid", out_valid, 0);
        check("midreset out_result", out_result, 0);
        check("midreset out_carry", out_carry, 0);
        check("midreset out_zero", out_zero, 0);
`ifdef BSALU_OVERFLOW_EN
        check("midreset out_ovf", out_ovf, 0);
`endif
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) check("aborted result never shown", out_valid, 0);
        end
        run_vec('{3'd0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < 16; i++)
            run_vec(model(3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom)));

        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
